// File: rtl/dp_pkg.sv
// Shared definitions for the dot-product command sequencer: FSM states,
// result status encodings and the default per-phase timeout.
package dp_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_FETCH      = 4'd1,
    ST_COMPUTE    = 4'd2,
    ST_WAIT_PROC  = 4'd3,
    ST_WRITE      = 4'd4,
    ST_WAIT_STORE = 4'd5,
    ST_READ       = 4'd6,
    ST_WAIT_READ  = 4'd7,
    ST_DONE       = 4'd8
  } dp_state_e;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_ZLEN  = 2'd1;
  localparam logic [1:0] ERR_TMO   = 2'd2;
  localparam logic [1:0] ERR_ABORT = 2'd3;

  localparam int DEFAULT_TMO_CYCLES = 32'sd1000;

endpackage

// File: rtl/dp_phase_timer.sv
// Per-phase watchdog: cleared outside the WAIT states, counts cycles inside
// them and flags the cycle in which the TMO_CYCLES-th wait cycle completes.
module dp_phase_timer
  import dp_pkg::*;
#(
  parameter int TMO_W      = 16,
  parameter int TMO_CYCLES = DEFAULT_TMO_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

  logic [TMO_W-1:0] count_r;
  logic             at_last_s;

  assign at_last_s = (count_r == TMO_LAST);
  // Expiry fires during the last permitted wait cycle so the FSM leaves on time.
  assign expired   = inc & at_last_s;

  // Wait-cycle counter; saturates at the last value instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc && !at_last_s) begin
      count_r <= count_r + TMO_W'(1);
    end
  end

endmodule

// File: rtl/dot_product_sequencer.sv
// Command-level controller: fetch -> compute -> write -> read with per-phase
// timeouts and abort, returning the read-back result with a status code.
module dot_product_sequencer
  import dp_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 8,
  parameter int TMO_W      = 16,
  parameter int TMO_CYCLES = DEFAULT_TMO_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              abort,
  output logic              start_fetch,
  output logic              start_compute,
  output logic              start_write,
  output logic              start_read,
  input  logic              processing_done,
  input  logic              store_done,
  input  logic              read_done,
  input  logic [DATA_W-1:0] read_data,
  output logic              busy,
  output logic              result_valid,
  output logic [DATA_W-1:0] result_data,
  output logic [1:0]        result_err
);

  dp_state_e         state_r;
  dp_state_e         fsm_next_s;
  dp_state_e         next_state_s;
  logic [1:0]        fsm_err_s;
  logic [1:0]        err_next_s;
  logic [LEN_W-1:0]  elem_cnt_r;
  logic [LEN_W-1:0]  elem_cnt_next_s;
  logic              abort_s;
  logic              tmr_clr_s;
  logic              tmr_inc_s;
  logic              tmr_expired_s;

  logic              start_fetch_r;
  logic              start_compute_r;
  logic              start_write_r;
  logic              start_read_r;
  logic              busy_r;
  logic              result_valid_r;
  logic [DATA_W-1:0] result_data_r;
  logic [1:0]        result_err_r;

  dp_phase_timer #(
    .TMO_W      (TMO_W),
    .TMO_CYCLES (TMO_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr_s),
    .inc     (tmr_inc_s),
    .expired (tmr_expired_s)
  );

  assign cmd_ready     = (state_r == ST_IDLE);
  assign start_fetch   = start_fetch_r;
  assign start_compute = start_compute_r;
  assign start_write   = start_write_r;
  assign start_read    = start_read_r;
  assign busy          = busy_r;
  assign result_valid  = result_valid_r;
  assign result_data   = result_data_r;
  assign result_err    = result_err_r;

  // Next-state, element-count and status decode; abort overrides the phase flow.
  always_comb begin
    fsm_next_s      = state_r;
    fsm_err_s       = ERR_OK;
    elem_cnt_next_s = elem_cnt_r;
    tmr_inc_s       = (state_r == ST_WAIT_PROC) || (state_r == ST_WAIT_STORE) ||
                      (state_r == ST_WAIT_READ);
    tmr_clr_s       = ~tmr_inc_s;
    abort_s         = abort && (state_r != ST_IDLE) && (state_r != ST_DONE);

    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            fsm_next_s = ST_DONE;
            fsm_err_s  = ERR_ZLEN;
          end else begin
            fsm_next_s      = ST_FETCH;
            elem_cnt_next_s = cmd_len;
          end
        end else begin
          fsm_next_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (elem_cnt_r <= LEN_W'(1)) begin
          fsm_next_s      = ST_COMPUTE;
          elem_cnt_next_s = '0;
        end else begin
          fsm_next_s      = ST_FETCH;
          elem_cnt_next_s = elem_cnt_r - LEN_W'(1);
        end
      end
      ST_COMPUTE: fsm_next_s = ST_WAIT_PROC;
      // A done input seen together with expiry still advances the phase.
      ST_WAIT_PROC: begin
        if (processing_done) begin
          fsm_next_s = ST_WRITE;
        end else if (tmr_expired_s) begin
          fsm_next_s = ST_DONE;
          fsm_err_s  = ERR_TMO;
        end else begin
          fsm_next_s = ST_WAIT_PROC;
        end
      end
      ST_WRITE: fsm_next_s = ST_WAIT_STORE;
      ST_WAIT_STORE: begin
        if (store_done) begin
          fsm_next_s = ST_READ;
        end else if (tmr_expired_s) begin
          fsm_next_s = ST_DONE;
          fsm_err_s  = ERR_TMO;
        end else begin
          fsm_next_s = ST_WAIT_STORE;
        end
      end
      ST_READ: fsm_next_s = ST_WAIT_READ;
      ST_WAIT_READ: begin
        if (read_done) begin
          fsm_next_s = ST_DONE;
        end else if (tmr_expired_s) begin
          fsm_next_s = ST_DONE;
          fsm_err_s  = ERR_TMO;
        end else begin
          fsm_next_s = ST_WAIT_READ;
        end
      end
      ST_DONE: fsm_next_s = ST_IDLE;
      default: fsm_next_s = ST_IDLE;
    endcase

    if (abort_s) begin
      next_state_s    = ST_DONE;
      err_next_s      = ERR_ABORT;
      elem_cnt_next_s = '0;
    end else begin
      next_state_s = fsm_next_s;
      err_next_s   = fsm_err_s;
    end
  end

  // State and element counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      elem_cnt_r <= '0;
    end else begin
      state_r    <= next_state_s;
      elem_cnt_r <= elem_cnt_next_s;
    end
  end

  // Outputs are registered from the next state so each one lines up with its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_fetch_r   <= 1'b0;
      start_compute_r <= 1'b0;
      start_write_r   <= 1'b0;
      start_read_r    <= 1'b0;
      busy_r          <= 1'b0;
      result_valid_r  <= 1'b0;
      result_data_r   <= '0;
      result_err_r    <= ERR_OK;
    end else begin
      start_fetch_r   <= (next_state_s == ST_FETCH);
      start_compute_r <= (next_state_s == ST_COMPUTE);
      start_write_r   <= (next_state_s == ST_WRITE);
      start_read_r    <= (next_state_s == ST_READ);
      busy_r          <= (next_state_s != ST_IDLE);
      result_valid_r  <= (next_state_s == ST_DONE);
      if (next_state_s == ST_DONE) begin
        result_err_r  <= err_next_s;
        result_data_r <= (err_next_s == ERR_OK) ? read_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Self-checking bench: drives commands and an accelerator responder, records
// when each output is high and compares against a phase-level timing model.
module tb_dot_product_sequencer;

  localparam int TMO   = 20;
  localparam int NEVER = 999;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_len = 8'd0;
  logic        abort = 1'b0;
  logic        start_fetch, start_compute, start_write, start_read;
  logic        processing_done = 1'b0;
  logic        store_done = 1'b0;
  logic        read_done = 1'b0;
  logic [31:0] read_data = 32'd0;
  logic        busy, result_valid;
  logic [31:0] result_data;
  logic [1:0]  result_err;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    int          f_first; int f_n;
    int          c_first; int c_n;
    int          w_first; int w_n;
    int          r_first; int r_n;
    int          rv_first; int rv_n;
    int          busy_n;
    logic [31:0] data;
    logic [31:0] hdata;
    logic [1:0]  err;
    logic [1:0]  herr;
    logic        ready_after;
    logic        rst_zero;
  } trace_t;

  dot_product_sequencer #(
    .DATA_W(32), .LEN_W(8), .TMO_W(16), .TMO_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .abort(abort), .start_fetch(start_fetch),
    .start_compute(start_compute), .start_write(start_write),
    .start_read(start_read), .processing_done(processing_done),
    .store_done(store_done), .read_done(read_done), .read_data(read_data),
    .busy(busy), .result_valid(result_valid), .result_data(result_data),
    .result_err(result_err)
  );

  always #5 clk = ~clk;

  function automatic string fmt(input trace_t t);
    return $sformatf("fetch@%0d x%0d comp@%0d x%0d write@%0d x%0d read@%0d x%0d valid@%0d x%0d busy x%0d data=%h err=%0d hold=%h/%0d rdy=%0b",
      t.f_first, t.f_n, t.c_first, t.c_n, t.w_first, t.w_n, t.r_first, t.r_n,
      t.rv_first, t.rv_n, t.busy_n, t.data, t.err, t.hdata, t.herr, t.ready_after);
  endfunction

  // Phase-level reference: cycles relative to command acceptance (cycle 0).
  function automatic trace_t expect_trace(input int len, dp, ds, dr,
                                          input logic [31:0] rdata, input int abort_a);
    trace_t e;
    int c, w, r, rv;
    logic [1:0] err;
    logic [31:0] data;
    e = '0;
    e.f_first = -1; e.c_first = -1; e.w_first = -1; e.r_first = -1;
    data = 32'd0;
    if (len == 0) begin
      rv = 1; err = 2'd1;
    end else if (abort_a >= 1 && abort_a <= len) begin
      e.f_first = 1; e.f_n = abort_a; rv = abort_a + 1; err = 2'd3;
    end else begin
      e.f_first = 1; e.f_n = len;
      c = len + 1; e.c_first = c; e.c_n = 1;
      if (dp >= 1 && dp <= TMO) begin
        w = c + dp + 1; e.w_first = w; e.w_n = 1;
        if (ds >= 1 && ds <= TMO) begin
          r = w + ds + 1; e.r_first = r; e.r_n = 1;
          if (dr >= 1 && dr <= TMO) begin
            rv = r + dr + 1; err = 2'd0; data = rdata;
          end else begin
            rv = r + TMO + 1; err = 2'd2;
          end
        end else begin
          rv = w + TMO + 1; err = 2'd2;
        end
      end else begin
        rv = c + TMO + 1; err = 2'd2;
      end
    end
    e.rv_first = rv; e.rv_n = 1; e.busy_n = rv;
    e.data = data; e.hdata = data; e.err = err; e.herr = err;
    e.ready_after = 1'b1;
    return e;
  endfunction

  // Runs one command from the current cycle (entered #1 after a rising edge).
  task automatic run_cmd(input int len, dp, ds, dr, input logic [31:0] rdata,
                         input int abort_a, spur, rst_at, output trace_t o);
    bit fin;
    fin = 1'b0;
    o = '0;
    o.f_first = -1; o.c_first = -1; o.w_first = -1; o.r_first = -1; o.rv_first = -1;
    for (int rel = 0; rel < 400; rel++) begin
      if (rel > 0) begin
        @(posedge clk); #1;
        if (rst_at > 0 && rel == rst_at + 1) begin
          o.rst_zero = !start_fetch && !start_compute && !start_write && !start_read &&
                       !busy && !result_valid && (result_data == 32'd0) && (result_err == 2'd0);
          fin = 1'b1;
        end else begin
          if (start_fetch)   begin o.f_n++; if (o.f_first < 0) o.f_first = rel; end
          if (start_compute) begin o.c_n++; if (o.c_first < 0) o.c_first = rel; end
          if (start_write)   begin o.w_n++; if (o.w_first < 0) o.w_first = rel; end
          if (start_read)    begin o.r_n++; if (o.r_first < 0) o.r_first = rel; end
          if (busy) o.busy_n++;
          if (result_valid) begin
            o.rv_n++;
            if (o.rv_first < 0) begin
              o.rv_first = rel; o.data = result_data; o.err = result_err;
            end
          end
          if (o.rv_first >= 0 && rel == o.rv_first + 1) begin
            o.ready_after = cmd_ready; o.hdata = result_data; o.herr = result_err;
            fin = 1'b1;
          end
        end
      end
      if (fin) begin
        cmd_valid = 1'b0; processing_done = 1'b0; store_done = 1'b0;
        read_done = 1'b0; abort = 1'b0; rst = 1'b0;
        break;
      end
      cmd_valid       = (rel == 0);
      cmd_len         = 8'(len);
      processing_done = (o.c_first >= 0 && rel == o.c_first + dp) || (spur != 0 && rel == 2);
      store_done      = (o.w_first >= 0 && rel == o.w_first + ds);
      read_done       = (o.r_first >= 0 && rel == o.r_first + dr);
      read_data       = read_done ? rdata : $urandom;
      abort           = (abort_a > 0 && rel == abort_a);
      rst             = (rst_at > 0 && rel == rst_at);
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL cmd_watchdog: no completion within 400 cycles, required one (len=%0d)", len);
      cmd_valid = 1'b0; processing_done = 1'b0; store_done = 1'b0;
      read_done = 1'b0; abort = 1'b0; rst = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({start_fetch, start_compute, start_write, start_read, busy, result_valid,
         result_data, result_err} !== 38'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b/%h/%0d, required all zero",
               {start_fetch, start_compute, start_write, start_read, busy, result_valid},
               result_data, result_err);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_ready: got ready=%b busy=%b, required ready=1 busy=0", cmd_ready, busy);
    end
  endtask

  task automatic test_basic;
    trace_t o, e;
    run_cmd(4, 3, 3, 3, 32'h6B, 0, 0, 0, o);
    e = expect_trace(4, 3, 3, 3, 32'h6B, 0);
    checks++;
    if (o !== e) begin errors++; $display("FAIL basic_trace: got %s | required %s", fmt(o), fmt(e)); end
    checks++;
    if (o.f_n !== 4) begin errors++; $display("FAIL basic_fetch_len: got %0d, required 4", o.f_n); end
    checks++;
    if ({o.c_n, o.w_n, o.r_n} !== {32'd1, 32'd1, 32'd1}) begin
      errors++; $display("FAIL basic_pulse_width: got %0d/%0d/%0d, required 1/1/1", o.c_n, o.w_n, o.r_n);
    end
    checks++;
    if (o.data !== 32'h6B || o.err !== 2'd0) begin
      errors++; $display("FAIL basic_result: got %h/%0d, required 0000006b/0", o.data, o.err);
    end
  endtask

  task automatic test_zero_len;
    trace_t o, e;
    run_cmd(0, 3, 3, 3, 32'h1234, 0, 0, 0, o);
    e = expect_trace(0, 3, 3, 3, 32'h1234, 0);
    checks++;
    if (o !== e) begin errors++; $display("FAIL zlen_trace: got %s | required %s", fmt(o), fmt(e)); end
    checks++;
    if (o.f_n + o.c_n + o.w_n + o.r_n != 0 || o.rv_first != 1 || o.err !== 2'd1) begin
      errors++;
      $display("FAIL zlen_result: got starts=%0d valid@%0d err=%0d, required 0/1/1",
               o.f_n + o.c_n + o.w_n + o.r_n, o.rv_first, o.err);
    end
  endtask

  task automatic test_timeout;
    trace_t o, e;
    run_cmd(3, 3, NEVER, 3, 32'hAAAA5555, 0, 0, 0, o);
    e = expect_trace(3, 3, NEVER, 3, 32'hAAAA5555, 0);
    checks++;
    if (o !== e) begin errors++; $display("FAIL tmo_trace: got %s | required %s", fmt(o), fmt(e)); end
    checks++;
    if (o.r_n != 0) begin errors++; $display("FAIL tmo_no_read: got %0d read pulses, required 0", o.r_n); end
    checks++;
    if (o.rv_first - o.w_first != TMO + 1) begin
      errors++; $display("FAIL tmo_latency: got %0d, required %0d", o.rv_first - o.w_first, TMO + 1);
    end
    checks++;
    if (o.err !== 2'd2) begin errors++; $display("FAIL tmo_err: got %0d, required 2", o.err); end
  endtask

  task automatic test_abort;
    trace_t o, e;
    run_cmd(5, 3, 3, 3, 32'h77, 2, 0, 0, o);
    e = expect_trace(5, 3, 3, 3, 32'h77, 2);
    checks++;
    if (o !== e) begin errors++; $display("FAIL abort_trace: got %s | required %s", fmt(o), fmt(e)); end
    checks++;
    if (o.f_n != 2) begin errors++; $display("FAIL abort_fetch: got %0d, required 2", o.f_n); end
    checks++;
    if (o.c_n != 0) begin errors++; $display("FAIL abort_compute: got %0d, required 0", o.c_n); end
    checks++;
    if (o.err !== 2'd3) begin errors++; $display("FAIL abort_err: got %0d, required 3", o.err); end
  endtask

  task automatic test_spurious_and_race;
    trace_t o, e;
    run_cmd(3, TMO, 2, 2, 32'hC0FFEE, 0, 1, 0, o);
    e = expect_trace(3, TMO, 2, 2, 32'hC0FFEE, 0);
    checks++;
    if (o !== e) begin errors++; $display("FAIL race_trace: got %s | required %s", fmt(o), fmt(e)); end
    checks++;
    if (o.w_n != 1 || o.err !== 2'd0) begin
      errors++; $display("FAIL race_result: got write=%0d err=%0d, required 1/0", o.w_n, o.err);
    end
    run_cmd(2, 0, 2, 2, 32'hBEEF, 0, 0, 0, o);
    e = expect_trace(2, 0, 2, 2, 32'hBEEF, 0);
    checks++;
    if (o !== e) begin errors++; $display("FAIL early_done_trace: got %s | required %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_reset_mid;
    trace_t o, e;
    run_cmd(3, 2, 2, NEVER, 32'h55, 0, 0, 13, o);
    checks++;
    if (o.r_n != 1 || o.rv_first != -1) begin
      errors++; $display("FAIL rstmid_reach: got read=%0d valid@%0d, required 1/-1", o.r_n, o.rv_first);
    end
    checks++;
    if (o.rst_zero !== 1'b1) begin errors++; $display("FAIL rstmid_outputs: got %b, required 1", o.rst_zero); end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b, required 1", cmd_ready); end
    run_cmd(2, 3, 3, 3, 32'h9E37, 0, 0, 0, o);
    e = expect_trace(2, 3, 3, 3, 32'h9E37, 0);
    checks++;
    if (o !== e) begin errors++; $display("FAIL rstmid_next: got %s | required %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_back_to_back;
    trace_t o, e;
    int len, d[3], ab;
    logic [31:0] rd;
    for (int n = 0; n < 25; n++) begin
      len = $urandom_range(0, 10);
      for (int k = 0; k < 3; k++)
        d[k] = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(1, TMO);
      ab = (len > 0 && $urandom_range(0, 6) == 0) ? $urandom_range(1, len) : 0;
      rd = $urandom;
      run_cmd(len, d[0], d[1], d[2], rd, ab, 0, 0, o);
      e = expect_trace(len, d[0], d[1], d[2], rd, ab);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b_%0d: got %s | required %s", n, fmt(o), fmt(e));
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero_len;
    test_timeout;
    test_abort;
    test_spurious_and_race;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
